// File: rtl/div_iter.sv
// div_iter: iterative restoring divider for the execute stage HI/LO path.
//
// A DIV (signed) or DIVU (unsigned) request is accepted while idle. The unit
// then produces one quotient bit per cycle for WIDTH cycles. One more cycle
// applies the signs and registers {remainder, quotient}.
//
// Ports:
//   clk       clock
//   rst       asynchronous, active-high reset
//   div_op    2'b10 = DIV (signed), 2'b01 = DIVU (unsigned), others = none
//   dividend  rs operand
//   divisor   rt operand
//   result    {remainder, quotient}, registered (HI = remainder, LO = quotient)
//   done      1 = idle and result valid, 0 = division in progress
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         div_op,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] result,
    output logic               done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t state, state_nxt;

    logic             armed;
    logic [CW-1:0]    cnt;
    logic             signed_op;
    logic             a_msb, b_msb;   // operand sign bits captured at accept
    logic             div_zero;
    logic [WIDTH-1:0] dvd_orig;       // kept for the divide-by-zero result
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;            // starts as |dividend|, shifts out into rem

    logic             op_valid;
    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             q_neg, r_neg;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign op_valid = (div_op == 2'b10) || (div_op == 2'b01);
    assign accept   = (state == IDLE) && op_valid && armed;

    // Only a signed op takes magnitudes of negative operands.
    assign a_neg = div_op[1] & dividend[WIDTH-1];
    assign b_neg = div_op[1] & divisor[WIDTH-1];

    // Restoring step. rem < divisor always holds, so the shifted remainder
    // minus the divisor lies strictly within +/-2^WIDTH and WIDTH+1 bits
    // suffice; the top bit is the borrow/sign.
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs_mag};

    assign q_neg   = signed_op & (a_msb ^ b_msb);
    assign r_neg   = signed_op & a_msb;
    assign quo_fix = q_neg ? (~quo + 1'b1) : quo;
    assign rem_fix = r_neg ? (~rem + 1'b1) : rem;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ITER;
            ITER:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: idle is exactly the "result valid" condition.
    always_comb begin
        done = (state == IDLE);
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            armed     <= 1'b1;
            cnt       <= '0;
            signed_op <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            div_zero  <= 1'b0;
            dvd_orig  <= '0;
            dvs_mag   <= '0;
            rem       <= '0;
            quo       <= '0;
        end else begin
            // A held request starts one division; a zero cycle re-arms.
            if (div_op == 2'b00) armed <= 1'b1;
            else if (accept)     armed <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        signed_op <= div_op[1];
                        a_msb     <= dividend[WIDTH-1];
                        b_msb     <= divisor[WIDTH-1];
                        div_zero  <= (divisor == '0);
                        dvd_orig  <= dividend;
                        quo       <= a_neg ? (~dividend + 1'b1) : dividend;
                        dvs_mag   <= b_neg ? (~divisor + 1'b1) : divisor;
                        rem       <= '0;
                        cnt       <= '0;
                    end
                end
                ITER: begin
                    if (trial[WIDTH]) begin
                        rem <= rem_sh[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end else begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (div_zero) result <= {dvd_orig, {WIDTH{1'b1}}};
                    else          result <= {rem_fix, quo_fix};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: a cycle-level reference model compared
// every cycle, plus directed vectors with hand-computed results.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  div_op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [63:0] result;
    logic        done;

    int total = 0;
    int bad   = 0;

    div_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .div_op(div_op),
        .dividend(dividend), .divisor(divisor),
        .result(result), .done(done)
    );

    always #5 clk = ~clk;

    // Reference arithmetic in 64-bit integers: truncating division, remainder
    // takes the dividend's sign, divide-by-zero yields {dividend, all ones}.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Model: busy for 33 cycles after an accept, result appears as done rises.
    logic        m_done;
    logic [63:0] m_res, m_pend;
    logic        m_armed;
    int          m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_done  <= 1'b1;
            m_res   <= '0;
            m_pend  <= '0;
            m_armed <= 1'b1;
            m_cnt   <= 0;
        end else begin
            logic acc;
            acc = (m_cnt == 0) && m_armed && (div_op == 2'b01 || div_op == 2'b10);
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_res  <= m_pend;
                end
            end else if (acc) begin
                m_cnt  <= 33;
                m_done <= 1'b0;
                m_pend <= ref_div(div_op == 2'b10, dividend, divisor);
            end
            if (div_op == 2'b00) m_armed <= 1'b1;
            else if (acc)        m_armed <= 1'b0;
        end
    end

    always @(negedge clk) begin
        total++;
        if (done !== m_done || result !== m_res) begin
            bad++;
            $display("FAIL cycle_check t=%0t got done=%b result=%h want done=%b result=%h",
                     $time, done, result, m_done, m_res);
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // Issue a one-cycle request, disturb operands mid-iteration, then measure
    // how long done stays low and check the final result.
    task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name);
        int lows;
        @(posedge clk); #1;
        div_op = op; dividend = a; divisor = b;
        @(posedge clk); #1;
        div_op = 2'b00; dividend = ~a; divisor = b ^ 32'h5A5A_5A5A;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
            lows++;
        end
        chk({name, "_latency"}, 64'(lows), 64'd33);
        chk(name, result, exp);
    endtask

    initial begin
        int falls, rises;
        logic prev;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_done", 64'(done), 64'd1);
        chk("reset_result", result, 64'd0);

        do_div(2'b01, 32'd100, 32'd7, {32'd2, 32'd14}, "divu_100_7");
        do_div(2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
        do_div(2'b10, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, "div_7_m2");
        do_div(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, "div_ovf");
        do_div(2'b01, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, "divu_max_1");
        do_div(2'b01, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, "divu_by0");
        do_div(2'b10, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, "div_by0");
        do_div(2'b01, 32'h8000_0000, 32'd3, {32'd2, 32'h2AAA_AAAA}, "divu_big_3");
        do_div(2'b10, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, "div_m100_7");

        // 2'b11 is not a request.
        @(posedge clk); #1;
        div_op = 2'b11; dividend = 32'd50; divisor = 32'd5;
        repeat (3) @(posedge clk);
        #1 chk("op11_ignored", 64'(done), 64'd1);
        div_op = 2'b00;

        // A long-held request starts exactly one division.
        @(posedge clk); #1;
        div_op = 2'b01; dividend = 32'd1000; divisor = 32'd10;
        falls = 0; rises = 0; prev = done;
        repeat (80) begin
            @(negedge clk);
            if (prev && !done) falls++;
            if (!prev && done) rises++;
            prev = done;
        end
        chk("held_falls", 64'(falls), 64'd1);
        chk("held_rises", 64'(rises), 64'd1);
        chk("held_result", result, {32'd0, 32'd100});

        // One zero cycle re-arms; the next request starts a new division.
        @(posedge clk); #1 div_op = 2'b00;
        @(posedge clk); #1 div_op = 2'b01; dividend = 32'd81; divisor = 32'd9;
        @(posedge clk); #1 div_op = 2'b00;
        @(negedge clk);
        chk("rearm_start", 64'(done), 64'd0);
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        chk("rearm_result", result, {32'd0, 32'd9});

        // Asynchronous reset in the middle of an iteration.
        @(posedge clk); #1 div_op = 2'b01; dividend = 32'd5000; divisor = 32'd7;
        @(posedge clk); #1 div_op = 2'b00;
        repeat (15) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_done", 64'(done), 64'd1);
        chk("async_rst_result", result, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        do_div(2'b01, 32'd9, 32'd3, {32'd0, 32'd3}, "divu_9_3_after_rst");

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
